// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer.
// Contents: FSM state and field encodings, centisecond conversion constants,
// and a binary-to-two-digit split helper used by the display path.
package countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_SET     = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSE   = 2'd2,
        ST_EXPIRED = 2'd3
    } state_e;

    typedef enum logic {
        FIELD_MIN = 1'b0,
        FIELD_SEC = 1'b1
    } field_e;

    localparam logic [19:0] CSEC_PER_MIN = 20'd6000;
    localparam logic [19:0] CSEC_PER_SEC = 20'd100;
    localparam logic [5:0]  SEC_MAX      = 6'd59;

    // Split a value 0..99 into {tens, ones} decimal digits.
    function automatic logic [7:0] split_bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

endpackage

// File: rtl/countdown_timer_key_release.sv
// Push-key synchroniser and release detector for one active-low key.
// Ports:
//   clk           : system clock
//   rst           : synchronous active-high reset, returns to "key released"
//   key_n         : raw active-low key pin
//   release_pulse : one-cycle pulse when the synchronised key goes 0 -> 1
// A pin rise is seen by sync2_q after the 2nd edge; the pulse is then high
// for one cycle and is consumed by the 3rd edge.
module countdown_timer_key_release (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic release_pulse
);

    logic sync1_q, sync1_d;
    logic sync2_q, sync2_d;
    logic prev_q,  prev_d;

    always_comb begin
        sync1_d = key_n;
        sync2_d = sync1_q;
        prev_d  = sync2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
        end
    end

    assign release_pulse = sync2_q & ~prev_q;

endmodule

// File: rtl/segment_7.sv
// Single-digit 7-segment encoder, active-low outputs.
// Ports:
//   digit : 4-bit value, 0..9 shown, anything else blanks the digit
//   seg   : [0:6] = segments a..g, 0 lights the segment
module segment_7 (
    input  logic [3:0] digit,
    output logic [0:6] seg
);

    always_comb begin
        case (digit)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/countdown_timer.sv
// Countdown timer board top: preset mm:ss with the keys, count down in
// 10 ms steps to 00:00.00 and raise ALARM.
// Ports:
//   CLOCK_50    : system clock
//   RESET       : synchronous active-high reset
//   KEY[2:0]    : active-low keys, [0] start/pause, [1] select/abort, [2] increment
//   HEX5..HEX0  : active-low digits, MM SS CC (HEX5 = minute tens)
//   ALARM       : high while the timer is expired
module countdown_timer
    import countdown_timer_pkg::*;
#(
    parameter int TICK_DIV = 500000,
    parameter int MAX_MIN  = 99
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic [2:0] KEY,
    output logic [0:6] HEX5,
    output logic [0:6] HEX4,
    output logic [0:6] HEX3,
    output logic [0:6] HEX2,
    output logic [0:6] HEX1,
    output logic [0:6] HEX0,
    output logic       ALARM
);

    localparam int             PW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [6:0]     MIN_LAST   = 7'(MAX_MIN);

    // Key events, one-hot after priority masking (KEY[0] > KEY[1] > KEY[2]).
    logic [2:0] key_pulse;
    logic       ev_start, ev_sel, ev_inc, ev_any;

    for (genvar i = 0; i < 3; i++) begin : g_key
        countdown_timer_key_release u_key (
            .clk           (CLOCK_50),
            .rst           (RESET),
            .key_n         (KEY[i]),
            .release_pulse (key_pulse[i])
        );
    end

    assign ev_start = key_pulse[0];
    assign ev_sel   = key_pulse[1] & ~key_pulse[0];
    assign ev_inc   = key_pulse[2] & ~(|key_pulse[1:0]);
    assign ev_any   = |key_pulse;

    state_e        state_q, state_d;
    field_e        field_q, field_d;
    logic [6:0]    preset_min_q, preset_min_d;
    logic [5:0]    preset_sec_q, preset_sec_d;
    logic [19:0]   count_q, count_d;
    logic [PW-1:0] prescaler_q, prescaler_d;

    logic [19:0]   preset_csec;
    logic          preset_nonzero;

    assign preset_csec    = 20'(preset_min_q) * CSEC_PER_MIN + 20'(preset_sec_q) * CSEC_PER_SEC;
    assign preset_nonzero = (preset_min_q != 7'd0) || (preset_sec_q != 6'd0);

    // State register (holds the FSM and its datapath).
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q      <= ST_SET;
            field_q      <= FIELD_MIN;
            preset_min_q <= 7'd0;
            preset_sec_q <= 6'd0;
            count_q      <= 20'd0;
            prescaler_q  <= '0;
        end else begin
            state_q      <= state_d;
            field_q      <= field_d;
            preset_min_q <= preset_min_d;
            preset_sec_q <= preset_sec_d;
            count_q      <= count_d;
            prescaler_q  <= prescaler_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d      = state_q;
        field_d      = field_q;
        preset_min_d = preset_min_q;
        preset_sec_d = preset_sec_q;
        count_d      = count_q;
        prescaler_d  = prescaler_q;

        case (state_q)
            ST_SET: begin
                if (ev_start) begin
                    // A zero preset would expire immediately, so start is ignored.
                    if (preset_nonzero) begin
                        count_d     = preset_csec;
                        prescaler_d = '0;
                        state_d     = ST_RUN;
                    end
                end else if (ev_sel) begin
                    field_d = (field_q == FIELD_MIN) ? FIELD_SEC : FIELD_MIN;
                end else if (ev_inc) begin
                    if (field_q == FIELD_MIN)
                        preset_min_d = (preset_min_q == MIN_LAST) ? 7'd0 : preset_min_q + 7'd1;
                    else
                        preset_sec_d = (preset_sec_q == SEC_MAX) ? 6'd0 : preset_sec_q + 6'd1;
                end
            end

            ST_RUN: begin
                // Pausing wins over a tick in the same cycle so the prescaler
                // value is held exactly and resumes without losing a tick.
                if (ev_start) begin
                    state_d = ST_PAUSE;
                end else if (prescaler_q == PRESC_LAST) begin
                    prescaler_d = '0;
                    if (count_q != 20'd0) begin
                        count_d = count_q - 20'd1;
                        if (count_q == 20'd1)
                            state_d = ST_EXPIRED;
                    end
                end else begin
                    prescaler_d = prescaler_q + 1'b1;
                end
            end

            ST_PAUSE: begin
                if (ev_start) begin
                    state_d = ST_RUN;
                end else if (ev_sel) begin
                    count_d = 20'd0;
                    state_d = ST_SET;
                end
            end

            ST_EXPIRED: begin
                count_d = 20'd0;
                if (ev_any)
                    state_d = ST_SET;
            end

            default: state_d = ST_SET;
        endcase
    end

    // Outputs: alarm flag and display digits, combinational from registers.
    logic [6:0] disp_min, disp_sec, disp_csec;
    logic [7:0] min_bcd, sec_bcd, csec_bcd;

    always_comb begin
        ALARM = (state_q == ST_EXPIRED);
        if (state_q == ST_SET) begin
            disp_min  = preset_min_q;
            disp_sec  = {1'b0, preset_sec_q};
            disp_csec = 7'd0;
        end else begin
            disp_min  = 7'(count_q / CSEC_PER_MIN);
            disp_sec  = 7'((count_q % CSEC_PER_MIN) / CSEC_PER_SEC);
            disp_csec = 7'(count_q % CSEC_PER_SEC);
        end
        min_bcd  = split_bcd(disp_min);
        sec_bcd  = split_bcd(disp_sec);
        csec_bcd = split_bcd(disp_csec);
    end

    segment_7 u_hex5 (.digit(min_bcd[7:4]),  .seg(HEX5));
    segment_7 u_hex4 (.digit(min_bcd[3:0]),  .seg(HEX4));
    segment_7 u_hex3 (.digit(sec_bcd[7:4]),  .seg(HEX3));
    segment_7 u_hex2 (.digit(sec_bcd[3:0]),  .seg(HEX2));
    segment_7 u_hex1 (.digit(csec_bcd[7:4]), .seg(HEX1));
    segment_7 u_hex0 (.digit(csec_bcd[3:0]), .seg(HEX0));

endmodule
